item_tag_tx: RTL and testbench
==============================

// Module: item_tag_tx
// PURPOSE
// - Serial transmitter for checkout item tags: accepts one parallel tag
//   (UPC code + secret mark bit), frames it and shifts it out on one wire.
// - Feeds the checkout sale/stolen detector, which recovers UPC and mark
//   from the line and sits at the receiving end of this link.
// - Frame, LSB-first never: start(0), UPC MSB..LSB, mark, even parity, stop(1).
// PARAMETERS
// - UPC_W       3  width of UPC code field
// - BIT_CYCLES  4  clock cycles per serial bit; legal range >= 1
// PORTS
// - clk        in   1      system clock, all logic on rising edge
// - reset      in   1      synchronous, active-high reset
// - tag_valid  in   1      parallel tag present on tag_upc/tag_mark
// - tag_ready  out  1      transmitter idle, will accept a tag this cycle
// - tag_upc    in   UPC_W  UPC code to send
// - tag_mark   in   1      secret mark bit to send
// - tx         out  1      serial line, idles high
// - busy       out  1      frame in progress
// - done       out  1      one-cycle pulse, last cycle of stop bit
// BEHAVIOUR
// - One clock (clk); reset is synchronous and active-high; all outputs registered.
// - Reset values: tx=1, tag_ready=1, busy=0, done=0, state IDLE, timer 0.
// - Reset mid-frame aborts: next cycle tx=1, tag_ready=1; no done pulse.
// - Handshake: transfer when tag_valid & tag_ready at a clk edge; upc/mark
//   latched into shift register that edge. tag_ready = (state==IDLE).
// - tag_valid while busy is ignored; input changes during a frame ignored.
// - FSM: IDLE -> START -> DATA (UPC_W bits) -> MARK -> PARITY -> STOP -> IDLE.
// - Each non-IDLE state holds BIT_CYCLES cycles; bit timer counts
//   0..BIT_CYCLES-1, advances state at terminal count, resets to 0 on entry.
// - Latency: accept at edge k; tx=0 (start) from cycle k+1; frame occupies
//   (UPC_W+4)*BIT_CYCLES cycles; done high in final STOP cycle; tag_ready
//   high the following cycle; back-to-back gap = exactly 1 idle cycle.
// - Parity bit = XOR(tag_upc, tag_mark) (total ones in UPC+mark+parity even).
// - DATA sends tag_upc[UPC_W-1] first; bit index counter wraps to DATA exit.
// - BIT_CYCLES=1: timer is 1 bit wide, terminal count every cycle.
// - busy = ~tag_ready; tx = 1 in IDLE and STOP.
// STRUCTURE
// - Package item_tag_pkg: state enum (IDLE,START,DATA,MARK,PARITY,STOP),
//   FRAME_BITS = UPC_W+4 helper function, TX_IDLE = 1'b1 constant.
// - Sub-module bit_timer (param BIT_CYCLES): counter with clear input and
//   terminal-count output; width max(1,$clog2(BIT_CYCLES)).
// - Top holds FSM, data-bit index, shift register, registered tx/done.
// TESTING (UPC_W=3, BIT_CYCLES=4)
// - Reset held 3 cycles -> tx=1, tag_ready=1, busy=0, done=0 throughout.
// - upc=3'b110, mark=1 -> tx 0,1,1,0,1,1,1 each 4 cycles (28 total);
//   done high cycle 28 after accept; tag_ready high cycle 29.
// - upc=3'b000, mark=0 -> tx 0,0,0,0,0,0,1; parity bit 0.
// - upc=3'b101, mark=0 held valid continuously -> two frames, 1 idle cycle
//   between; bits 0,1,0,1,0,0,1; input change mid-frame has no effect.
// - Reset asserted at cycle 10 of a frame -> tx=1, tag_ready=1 next cycle,
//   no done; new tag afterwards transmits a complete, correct frame.
// - BIT_CYCLES=1 build: upc=3'b011, mark=1 -> tx 0,0,1,1,1,1,1 one per cycle.

Source files
------------

// File: rtl/item_tag_pkg.sv
// Shared types and constants for the checkout item-tag serial transmitter.
package item_tag_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        MARK   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_e;

    localparam logic TX_IDLE = 1'b1;

    // Serial bits per frame: start, UPC bits, mark, parity, stop.
    function automatic int frame_bits(input int upc_w);
        return upc_w + 4;
    endfunction

endpackage

// File: rtl/item_tag_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..BIT_CYCLES-1 and flags the terminal count.
module bit_timer #(
    parameter int BIT_CYCLES = 4,
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count_r;
    logic          tc_s;

    // Terminal count decode from the registered counter.
    always_comb begin
        tc_s = (count_r == CNT_LAST);
    end

    // Counter wraps at terminal count and is held at zero while cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else if (clear || tc_s) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign count = count_r;
    assign tc    = tc_s;

endmodule

// File: rtl/item_tag_tx.sv
// Item-tag serial transmitter: frames UPC + mark with even parity onto one wire.
module item_tag_tx
    import item_tag_pkg::*;
#(
    parameter int UPC_W      = 3,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tag_valid,
    output logic             tag_ready,
    input  logic [UPC_W-1:0] tag_upc,
    input  logic             tag_mark,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int FRAME_BITS = frame_bits(UPC_W);
    localparam int SHIFT_W    = FRAME_BITS - 2;
    localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW         = (UPC_W > 1) ? $clog2(UPC_W) : 1;

    localparam logic [IW-1:0]      IDX_ZERO   = IW'(1'b0);
    localparam logic [IW-1:0]      IDX_ONE    = IW'(1'b1);
    localparam logic [IW-1:0]      IDX_LAST   = IW'(UPC_W - 1);
    localparam logic [SHIFT_W-1:0] SHIFT_ZERO = SHIFT_W'(1'b0);
    // done is registered, so it is armed one cycle before the last stop cycle.
    localparam logic [CW-1:0]      DONE_AT    = (BIT_CYCLES > 1) ? CW'(BIT_CYCLES - 2) : CW'(1'b0);
    localparam logic               ONE_CYCLE  = (BIT_CYCLES == 1) ? 1'b1 : 1'b0;

    function automatic logic calc_parity(input logic [UPC_W-1:0] upc, input logic mark);
        return ^{upc, mark};
    endfunction

    tx_state_e          state_r;
    logic [SHIFT_W-1:0] shift_r;
    logic [IW-1:0]      idx_r;
    logic               tx_r;
    logic               done_r;
    logic               ready_r;
    logic               busy_r;

    logic               clear_s;
    logic [CW-1:0]      count_s;
    logic               tc_s;
    logic               done_set_s;
    logic [SHIFT_W-1:0] shift_next_s;

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .count (count_s),
        .tc    (tc_s)
    );

    // Timer clear, shifted data and the done-arming condition.
    always_comb begin
        clear_s      = (state_r == IDLE);
        shift_next_s = {shift_r[SHIFT_W-2:0], 1'b0};
        done_set_s   = 1'b0;
        if (ONE_CYCLE) begin
            done_set_s = (state_r == PARITY) && tc_s;
        end else begin
            done_set_s = (state_r == STOP) && (count_s == DONE_AT);
        end
    end

    // Frame FSM; tx always carries the bit of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= SHIFT_ZERO;
            idx_r   <= IDX_ZERO;
            tx_r    <= TX_IDLE;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            done_r <= done_set_s;
            case (state_r)
                IDLE: begin
                    if (tag_valid) begin
                        state_r <= START;
                        shift_r <= {tag_upc, tag_mark, calc_parity(tag_upc, tag_mark)};
                        idx_r   <= IDX_ZERO;
                        tx_r    <= 1'b0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        tx_r <= TX_IDLE;
                    end
                end
                START: begin
                    if (tc_s) begin
                        state_r <= DATA;
                        tx_r    <= shift_r[SHIFT_W-1];
                        shift_r <= shift_next_s;
                        idx_r   <= IDX_ZERO;
                    end
                end
                DATA: begin
                    if (tc_s) begin
                        tx_r    <= shift_r[SHIFT_W-1];
                        shift_r <= shift_next_s;
                        if (idx_r == IDX_LAST) begin
                            state_r <= MARK;
                            idx_r   <= IDX_ZERO;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                MARK: begin
                    if (tc_s) begin
                        state_r <= PARITY;
                        tx_r    <= shift_r[SHIFT_W-1];
                        shift_r <= shift_next_s;
                    end
                end
                PARITY: begin
                    if (tc_s) begin
                        state_r <= STOP;
                        tx_r    <= TX_IDLE;
                    end
                end
                STOP: begin
                    if (tc_s) begin
                        state_r <= IDLE;
                        tx_r    <= TX_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= TX_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tag_ready = ready_r;
    assign busy      = busy_r;
    assign tx        = tx_r;
    assign done      = done_r;

endmodule

// File: tb/tb_item_tag_tx.sv
// Directed bench for item_tag_tx: BIT_CYCLES=4 main instance plus a BIT_CYCLES=1 instance.
module tb_item_tag_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tag_valid;
    logic [2:0] tag_upc;
    logic       tag_mark;
    logic       tag_ready, tx, busy, done;
    logic       tag_valid1;
    logic [2:0] tag_upc1;
    logic       tag_mark1;
    logic       tag_ready1, tx1, busy1, done1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    item_tag_tx #(.UPC_W(3), .BIT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .tag_valid(tag_valid), .tag_ready(tag_ready),
        .tag_upc(tag_upc), .tag_mark(tag_mark), .tx(tx), .busy(busy), .done(done)
    );

    item_tag_tx #(.UPC_W(3), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .tag_valid(tag_valid1), .tag_ready(tag_ready1),
        .tag_upc(tag_upc1), .tag_mark(tag_mark1), .tx(tx1), .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tag_valid = 1'b0; tag_upc = 3'b000; tag_mark = 1'b0;
        tag_valid1 = 1'b0; tag_upc1 = 3'b000; tag_mark1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({tx, tag_ready, busy, done} !== 4'b1100) begin
                bad++;
                $display("FAIL reset_main cycle %0d: tx/ready/busy/done=%b want 1100", i, {tx, tag_ready, busy, done});
            end
            total++;
            if ({tx1, tag_ready1, busy1, done1} !== 4'b1100) begin
                bad++;
                $display("FAIL reset_bc1 cycle %0d: tx/ready/busy/done=%b want 1100", i, {tx1, tag_ready1, busy1, done1});
            end
        end
        reset = 1'b0;
    endtask

    task automatic accept(input logic [2:0] upc, input logic mark, input bit hold);
        int n = 0;
        while (tag_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (tag_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait: tag_ready=%b want 1", tag_ready);
        end
        tag_upc = upc; tag_mark = mark; tag_valid = 1'b1;
        tick();
        if (!hold) tag_valid = 1'b0;
    endtask

    // Starts in the first cycle after the accept edge; ends in the cycle after the frame.
    task automatic check_frame(input logic [6:0] bits, input string nm, input bit perturb);
        for (int c = 1; c <= 28; c++) begin
            logic exp_tx;
            logic exp_done;
            exp_tx   = bits[6 - (c - 1) / 4];
            exp_done = (c == 28);
            if (perturb && c == 10) begin
                tag_upc = 3'b010; tag_mark = 1'b1;
            end
            if (perturb && c == 20) begin
                tag_upc = 3'b101; tag_mark = 1'b0;
            end
            total++;
            if (tx !== exp_tx) begin
                bad++;
                $display("FAIL %s tx cycle %0d: got %b want %b", nm, c, tx, exp_tx);
            end
            total++;
            if ({tag_ready, busy, done} !== {1'b0, 1'b1, exp_done}) begin
                bad++;
                $display("FAIL %s ctl cycle %0d: ready/busy/done=%b want %b", nm, c, {tag_ready, busy, done}, {1'b0, 1'b1, exp_done});
            end
            tick();
        end
        total++;
        if ({tx, tag_ready, busy, done} !== 4'b1100) begin
            bad++;
            $display("FAIL %s post: tx/ready/busy/done=%b want 1100", nm, {tx, tag_ready, busy, done});
        end
    endtask

    task automatic test_basic();
        accept(3'b110, 1'b1, 1'b0);
        check_frame(7'b0110111, "upc110_m1", 1'b0);
    endtask

    task automatic test_zero();
        accept(3'b000, 1'b0, 1'b0);
        check_frame(7'b0000001, "upc000_m0", 1'b0);
    endtask

    task automatic test_back_to_back();
        accept(3'b101, 1'b0, 1'b1);
        check_frame(7'b0101001, "b2b_first", 1'b1);
        tick();
        tag_valid = 1'b0;
        check_frame(7'b0101001, "b2b_second", 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int stray = 0;
        accept(3'b110, 1'b1, 1'b0);
        repeat (9) tick();
        total++;
        if (tx !== 1'b1) begin
            bad++;
            $display("FAIL midframe_cycle10 tx: got %b want 1", tx);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({tx, tag_ready, busy, done} !== 4'b1100) begin
            bad++;
            $display("FAIL midframe_reset: tx/ready/busy/done=%b want 1100", {tx, tag_ready, busy, done});
        end
        for (int i = 0; i < 30; i++) begin
            if (done !== 1'b0 || tx !== 1'b1) stray++;
            tick();
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL midframe_quiet: %0d cycles with done or tx low, want 0", stray);
        end
        accept(3'b011, 1'b0, 1'b0);
        check_frame(7'b0011001, "after_reset", 1'b0);
    endtask

    task automatic test_single_cycle();
        logic [6:0] bits;
        int n = 0;
        bits = 7'b0011111;
        while (tag_ready1 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tag_upc1 = 3'b011; tag_mark1 = 1'b1; tag_valid1 = 1'b1;
        tick();
        tag_valid1 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            logic exp_done;
            exp_done = (c == 7);
            total++;
            if (tx1 !== bits[7 - c]) begin
                bad++;
                $display("FAIL bc1 tx cycle %0d: got %b want %b", c, tx1, bits[7 - c]);
            end
            total++;
            if ({tag_ready1, busy1, done1} !== {1'b0, 1'b1, exp_done}) begin
                bad++;
                $display("FAIL bc1 ctl cycle %0d: ready/busy/done=%b want %b", c, {tag_ready1, busy1, done1}, {1'b0, 1'b1, exp_done});
            end
            tick();
        end
        total++;
        if ({tx1, tag_ready1, busy1, done1} !== 4'b1100) begin
            bad++;
            $display("FAIL bc1 post: tx/ready/busy/done=%b want 1100", {tx1, tag_ready1, busy1, done1});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_back_to_back();
        test_reset_mid_frame();
        test_single_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
